vector_max_pool: RTL
====================

# vector_max_pool

Streaming element-wise max-pooling stage placed directly downstream of the ReLu activation stage in the TTPU datapath. It accepts activation vectors of LENGTH signed lanes over a valid/ready handshake and merges WINDOW consecutive vectors by per-lane signed maximum. It emits one pooled vector per window toward the output buffer. An early-close input flushes a partial window at the end of a row.

## Interface
Parameters:
- DATA_WIDTH, 16, lane width, two's-complement signed
- LENGTH, 64, lanes per vector
- WINDOW, 2, vectors merged per output; legal range 2..16
- CW, $clog2(WINDOW+1), derived width of the count fields

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; asserted when reset==0 at a rising edge
- in_valid  in  1  In/in_last are valid
- in_ready  out  1  stage can accept a vector this cycle
- In  in  [LENGTH-1:0][DATA_WIDTH-1:0]  activation vector (ReLu output)
- in_last  in  1  accepted vector closes the current window early
- out_valid  out  1  Out/out_count are valid
- out_ready  in  1  consumer accepts the output this cycle
- Out  out  [LENGTH-1:0][DATA_WIDTH-1:0]  pooled vector
- out_count  out  CW  number of input vectors merged into Out, 1..WINDOW

## Operation
- Input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Internal state: acc (LENGTH lanes), cnt (CW bits), FSM with states ACCUM and HOLD.
- ACCUM, on an input transfer:
  - If cnt==0, acc <= In.
  - Otherwise acc[i] <= signed max(acc[i], In[i]) for each lane. Ties keep the existing value; the result is bit-identical either way.
  - cnt <= cnt+1.
  - If cnt+1==WINDOW or in_last, move to HOLD and drive Out=acc_next and out_count=cnt+1.
- HOLD: out_valid=1; Out and out_count stay stable until the output transfer.
- On an output transfer in HOLD:
  - With no simultaneous input transfer: return to ACCUM with cnt=0.
  - With a simultaneous input transfer: that vector opens the next window (acc<=In, cnt<=1). If WINDOW-complete or in_last also holds, stay in HOLD with the new single-vector result.
- in_ready = (state==ACCUM) || out_ready. Combinational from out_ready; no other combinational input-to-output path.
- in_last on the first vector of a window emits that vector unchanged with out_count=1.
- Comparison is signed over the full DATA_WIDTH. There is no saturation or width growth; the output width equals the input width.
- In HOLD with out_ready=0, input is back-pressured (in_ready=0) and acc is not modified.

## Timing
- Reset values: out_valid=0, Out=0, out_count=0, acc=0, cnt=0, state=ACCUM.
- in_ready is 0 during any cycle in which reset==0; it is 1 from the first cycle after release.
- Latency: out_valid rises the cycle after the input transfer that closes the window.
- Sustained throughput: one input vector per cycle when out_ready is held at 1. Output rate is one pooled vector per WINDOW cycles, with no bubbles at window boundaries.
- Reset asserted mid-window or in HOLD discards the partial or pending result. No output is produced for it.
- Out, out_count and out_valid are registered outputs.

## Structure
- Shared package ttpu_pkg:
  - default DATA_WIDTH / LENGTH constants, shared with ReLu
  - typedef pool_state_t {ACCUM, HOLD}
- Sub-module vec_smax: a combinational per-lane signed max of two LENGTH-lane vectors. It is instantiated once, is reusable by later pooling variants, and is tested standalone.
- Top module holds the FSM, cnt, the acc register and the handshake logic.

## Test plan
- Basic window: WINDOW=2, out_ready=1. Inputs lane0 = 5 then 9, lane1 = 0x7FFF then 3. Required: one output one cycle after the second input, with lane0=9, lane1=0x7FFF, out_count=2.
- Signed compare: lane0 = 0xFFFF (-1) then 0x0000. Required: Out lane0=0x0000. Also lane0 = 0x8000 then 0xFFFF; required: 0xFFFF.
- Early close: WINDOW=4, three vectors with in_last on the third. Required: out_count=3, Out equals the lane max of the three, and the next window restarts at cnt=0.
- Back-pressure: hold out_ready=0 for 5 cycles in HOLD. Required: in_ready=0, and Out/out_count stable. On release with in_valid=1, the output transfer and the next window's first input occur in the same cycle.
- Streaming: out_ready=1, in_valid=1 for 8 cycles, WINDOW=2. Required: exactly 4 outputs on alternating cycles and no dropped input vectors.
- Reset mid-window: reset=0 after one vector of a window. Required: out_valid=0 and Out=0 next cycle, and no stale output after release.

Source files
------------

// File: rtl/ttpu_pkg.sv
// rtl/ttpu_pkg.sv - shared TTPU datapath constants and pooling state type
package ttpu_pkg;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_LENGTH     = 64;
    localparam int DEFAULT_WINDOW     = 2;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } pool_state_t;
endpackage

// File: rtl/vec_smax.sv
// rtl/vec_smax.sv - combinational per-lane signed maximum of two vectors
module vec_smax
    import ttpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LENGTH     = DEFAULT_LENGTH
) (
    input  logic [LENGTH-1:0][DATA_WIDTH-1:0] a,
    input  logic [LENGTH-1:0][DATA_WIDTH-1:0] b,
    output logic [LENGTH-1:0][DATA_WIDTH-1:0] y
);
    // Ties select a, so the existing accumulator value is kept.
    always_comb begin
        for (int i = 0; i < LENGTH; i++) begin
            y[i] = ($signed(b[i]) > $signed(a[i])) ? b[i] : a[i];
        end
    end
endmodule

// File: rtl/vector_max_pool.sv
// rtl/vector_max_pool.sv - streaming per-lane signed max-pool over WINDOW vectors
module vector_max_pool
    import ttpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LENGTH     = DEFAULT_LENGTH,
    parameter int WINDOW     = DEFAULT_WINDOW,
    parameter int CW         = $clog2(WINDOW + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [LENGTH-1:0][DATA_WIDTH-1:0]  In,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [LENGTH-1:0][DATA_WIDTH-1:0]  Out,
    output logic [CW-1:0]                      out_count
);
    typedef logic [LENGTH-1:0][DATA_WIDTH-1:0] vec_t;

    pool_state_t    state, state_next;
    vec_t           acc, acc_next, merged, window_data, pooled_next;
    logic [CW-1:0]  cnt, cnt_next, base_cnt, inc_cnt, count_next;
    logic           valid_next, in_xfer, out_xfer, close;

    vec_smax #(
        .DATA_WIDTH (DATA_WIDTH),
        .LENGTH     (LENGTH)
    ) u_smax (
        .a (acc),
        .b (In),
        .y (merged)
    );

    assign in_ready = reset && ((state == ACCUM) || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // In HOLD, an accepted vector always opens a fresh window.
    assign base_cnt    = (state == HOLD) ? '0 : cnt;
    assign inc_cnt     = base_cnt + CW'(1);
    assign window_data = (base_cnt == '0) ? In : merged;
    assign close       = (inc_cnt == CW'(WINDOW)) || in_last;

    always_comb begin
        state_next  = state;
        acc_next    = acc;
        cnt_next    = cnt;
        valid_next  = out_valid;
        pooled_next = Out;
        count_next  = out_count;
        if ((state == HOLD) && out_xfer) begin
            state_next = ACCUM;
            cnt_next   = '0;
            valid_next = 1'b0;
        end
        if (in_xfer) begin
            acc_next = window_data;
            cnt_next = inc_cnt;
            if (close) begin
                state_next  = HOLD;
                valid_next  = 1'b1;
                pooled_next = window_data;
                count_next  = inc_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            Out       <= '0;
            out_count <= '0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            out_valid <= valid_next;
            Out       <= pooled_next;
            out_count <= count_next;
        end
    end
endmodule
